ones_pattern_gen: RTL

- Inverse companion of the combinational popcount block: given a ones-count K, enumerates every WIDTH-bit word whose popcount equals K.
- Words come out in ascending numeric order, one per accepted handshake.
- Sits upstream of popcount checkers and bit-balanced code tables, and serves as a stimulus/test-vector source for them.

---
 rtl/ones_pattern_gen_if.sv | 29 ++
 rtl/ones_pattern_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ones_pattern_gen_if.sv
// Handshake bundle for the ones-count pattern generator.
// The generator side uses the master modport and the consumer side uses the slave modport.
interface ones_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = 7
);
  logic             i_start;
  logic [CNT_W-1:0] i_count;
  logic             i_abort;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [IDX_W-1:0] o_index;
  logic             o_last;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  modport master (
    input  i_start, i_count, i_abort, i_ready,
    output o_valid, o_data, o_index, o_last, o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_count, i_abort, i_ready,
    input  o_valid, o_data, o_index, o_last, o_busy, o_done, o_err
  );
endinterface

// File: rtl/ones_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly K ones, in ascending numeric order.
// Each accepted handshake advances to the next word using Gosper's hack.
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = 7
) (
  input logic                i_clk,
  input logic                i_rst,
  ones_pattern_gen_if.master bus
);
  localparam int SH_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pattern_reg;
  logic [IDX_W-1:0] index_reg;
  logic [CNT_W-1:0] k_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic [WIDTH-1:0] start_pat;
  logic [WIDTH-1:0] last_pat;
  logic [WIDTH-1:0] lowest_bit;
  logic [WIDTH:0]   ripple;
  logic [WIDTH:0]   changed;
  logic [WIDTH:0]   next_full;
  logic [WIDTH-1:0] next_pat;
  logic [SH_W-1:0]  tz;
  logic [SH_W-1:0]  shamt;
  logic             carry_unused;
  logic             is_last;

  // First word has the K low bits set; final word has the K high bits set.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      assign start_pat[gi] = (CNT_W'(gi) < bus.i_count);
      assign last_pat[gi]  = (({1'b0, k_reg} + (CNT_W+1)'(gi)) >= (CNT_W+1)'(WIDTH));
    end
  endgenerate

  // Trailing-zero count of the isolated lowest set bit, replacing the divide by c.
  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lowest_bit[i]) tz = SH_W'(i);
    end
  end

  // Gosper step: the carry ripple moves the lowest run up one place, and the leftover ones are refilled at the bottom.
  assign lowest_bit   = pattern_reg & (-pattern_reg);
  assign ripple       = {1'b0, pattern_reg} + {1'b0, lowest_bit};
  assign changed      = ripple ^ {1'b0, pattern_reg};
  assign shamt        = tz + SH_W'(2);
  assign next_full    = ripple | (changed >> shamt);
  assign next_pat     = next_full[WIDTH-1:0];
  // The carry out is only set for the final word, and that word is never advanced.
  assign carry_unused = next_full[WIDTH];

  assign is_last = valid_reg && (pattern_reg == last_pat);

  // Controller: accepts a start in IDLE and steps the pattern on each accepted handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      index_reg   <= '0;
      k_reg       <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            if (bus.i_count > WIDTH_CNT) begin
              err_reg <= 1'b1;
            end else begin
              pattern_reg <= start_pat;
              index_reg   <= '0;
              k_reg       <= bus.i_count;
              valid_reg   <= 1'b1;
              busy_reg    <= 1'b1;
              state_reg   <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.i_abort) begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.i_ready) begin
            if (is_last) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              pattern_reg <= next_pat;
              index_reg   <= index_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_valid = valid_reg;
  assign bus.o_data  = pattern_reg;
  assign bus.o_index = index_reg;
  assign bus.o_last  = is_last;
  assign bus.o_busy  = busy_reg;
  assign bus.o_done  = done_reg;
  assign bus.o_err   = err_reg;
endmodule
